dcache_ctrl: RTL and testbench

- Direct-mapped, write-back, write-allocate data cache controller for the MEM stage.
- Produces the memory-stall signal consumed by PC, IF/ID and the other pipeline registers. These hold their contents while the stall is high.
- Fronts a 256-bit-line off-chip data memory using an enable/ack handshake.
- Tag, valid, dirty and data arrays are internal registers.

---
 rtl/dcache_ctrl.sv | 132 +++++++++++++
 tb/tb_dcache_ctrl.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/dcache_ctrl.sv
// Direct-mapped, write-back, write-allocate data cache controller for the MEM stage.
// Stalls the pipeline on a miss and talks to a 256-bit-line memory over an enable/ack handshake.
module dcache_ctrl #(
  parameter int NUM_LINES = 32,
  parameter int LINE_W    = 256,
  parameter int TAG_W     = 22
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [31:0]       p1_addr_i,
  input  logic [31:0]       p1_data_i,
  input  logic              p1_MemRead_i,
  input  logic              p1_MemWrite_i,
  output logic [31:0]       p1_data_o,
  output logic              p1_stall_o,
  input  logic [LINE_W-1:0] mem_data_i,
  input  logic              mem_ack_i,
  output logic [LINE_W-1:0] mem_data_o,
  output logic [31:0]       mem_addr_o,
  output logic              mem_enable_o,
  output logic              mem_write_o
);

  localparam int IDX_W = $clog2(NUM_LINES);

  typedef enum logic [1:0] {IDLE, WRITEBACK, READMISS, REFILLED} state_e;

  state_e               state_q;
  logic [TAG_W-1:0]     tag_q   [NUM_LINES];
  logic [LINE_W-1:0]    data_q  [NUM_LINES];
  logic [NUM_LINES-1:0] valid_q;
  logic [NUM_LINES-1:0] dirty_q;
  logic [TAG_W-1:0]     miss_tag_q;
  logic [IDX_W-1:0]     miss_idx_q;
  logic                 mem_enable_q;
  logic                 mem_write_q;
  logic [31:0]          mem_addr_q;
  logic [LINE_W-1:0]    mem_data_q;

  logic [TAG_W-1:0]  req_tag;
  logic [IDX_W-1:0]  req_idx;
  logic [2:0]        req_word;
  logic [LINE_W-1:0] cur_line;
  logic              req;
  logic              hit;
  logic              store_en;
  logic              fill_en;
  logic              unused_addr;

  assign req_tag     = p1_addr_i[31 -: TAG_W];
  assign req_idx     = p1_addr_i[5 +: IDX_W];
  assign req_word    = p1_addr_i[4:2];
  assign unused_addr = ^p1_addr_i[1:0];
  assign cur_line    = data_q[req_idx];
  assign req         = p1_MemRead_i | p1_MemWrite_i;
  assign hit         = valid_q[req_idx] & (tag_q[req_idx] == req_tag);
  assign store_en    = (state_q == IDLE) & p1_MemWrite_i & hit;
  assign fill_en     = (state_q == READMISS) & mem_ack_i;

  // A miss stalls in the same cycle it is seen; reset forces the stall low.
  assign p1_stall_o  = rst_i & ((state_q != IDLE) | (req & ~hit));
  assign p1_data_o   = ((state_q == IDLE) & req & hit) ? cur_line[{req_word, 5'b00000} +: 32] : 32'h0;

  assign mem_enable_o = mem_enable_q;
  assign mem_write_o  = mem_write_q;
  assign mem_addr_o   = mem_addr_q;
  assign mem_data_o   = mem_data_q;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q      <= IDLE;
      valid_q      <= '0;
      dirty_q      <= '0;
      miss_tag_q   <= '0;
      miss_idx_q   <= '0;
      mem_enable_q <= 1'b0;
      mem_write_q  <= 1'b0;
      mem_addr_q   <= '0;
      mem_data_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (req && !hit) begin
            miss_tag_q   <= req_tag;
            miss_idx_q   <= req_idx;
            mem_enable_q <= 1'b1;
            if (valid_q[req_idx] && dirty_q[req_idx]) begin
              state_q     <= WRITEBACK;
              mem_write_q <= 1'b1;
              mem_addr_q  <= {tag_q[req_idx], req_idx, 5'b00000};
              mem_data_q  <= cur_line;
            end else begin
              state_q     <= READMISS;
              mem_write_q <= 1'b0;
              mem_addr_q  <= {req_tag, req_idx, 5'b00000};
            end
          end else if (store_en) begin
            dirty_q[req_idx] <= 1'b1;
          end
        end
        WRITEBACK: begin
          if (mem_ack_i) begin
            state_q     <= READMISS;
            mem_write_q <= 1'b0;
            mem_addr_q  <= {miss_tag_q, miss_idx_q, 5'b00000};
          end
        end
        READMISS: begin
          if (mem_ack_i) begin
            state_q              <= REFILLED;
            mem_enable_q         <= 1'b0;
            valid_q[miss_idx_q]  <= 1'b1;
            dirty_q[miss_idx_q]  <= 1'b0;
          end
        end
        REFILLED: state_q <= IDLE;
        default:  state_q <= IDLE;
      endcase
    end
  end

  // Tag and data arrays carry no reset; valid bits guard their contents.
  always_ff @(posedge clk_i) begin
    if (fill_en) begin
      data_q[miss_idx_q] <= mem_data_i;
      tag_q[miss_idx_q]  <= miss_tag_q;
    end else if (store_en) begin
      data_q[req_idx][{req_word, 5'b00000} +: 32] <= p1_data_i;
    end
  end

endmodule

// File: tb/tb_dcache_ctrl.sv
// Directed testbench for dcache_ctrl: hand-driven memory responder and hand-computed expectations.
module tb_dcache_ctrl;

  logic         clk = 1'b0;
  logic         rstN;
  logic [31:0]  p1Addr;
  logic [31:0]  p1Wdata;
  logic         p1Read;
  logic         p1Write;
  logic [31:0]  p1Rdata;
  logic         p1Stall;
  logic [255:0] memRdata;
  logic         memAck;
  logic [255:0] memWdata;
  logic [31:0]  memAddr;
  logic         memEn;
  logic         memWe;

  int checks   = 0;
  int failures = 0;

  logic [255:0] line1, line2, line3, line4, line5, line6, junk, wb;

  always #5 clk = ~clk;

  dcache_ctrl dut (
    .clk_i        (clk),
    .rst_i        (rstN),
    .p1_addr_i    (p1Addr),
    .p1_data_i    (p1Wdata),
    .p1_MemRead_i (p1Read),
    .p1_MemWrite_i(p1Write),
    .p1_data_o    (p1Rdata),
    .p1_stall_o   (p1Stall),
    .mem_data_i   (memRdata),
    .mem_ack_i    (memAck),
    .mem_data_o   (memWdata),
    .mem_addr_o   (memAddr),
    .mem_enable_o (memEn),
    .mem_write_o  (memWe)
  );

  task automatic checkOutput(input string tag, input logic [255:0] got, input logic [255:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("[TB] FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic applyStimulus(input logic rd, input logic wr, input logic [31:0] addr, input logic [31:0] data);
    p1Read  = rd;
    p1Write = wr;
    p1Addr  = addr;
    p1Wdata = data;
  endtask

  // Waits (bounded) for a memory request, checks it, holds it for 'latency' cycles, then acks.
  // Returns at the falling edge after the ack cycle.
  task automatic memRespond(input string tag, input logic expWe, input logic [31:0] expAddr,
                            input int latency, input logic [255:0] line, output logic [255:0] wbLine);
    int n = 0;
    while (!memEn && n < 50) begin
      @(negedge clk);
      n++;
    end
    checkOutput({tag, "_en"}, 256'(memEn), 256'(1'b1));
    checkOutput({tag, "_we"}, 256'(memWe), 256'(expWe));
    checkOutput({tag, "_addr"}, 256'(memAddr), 256'(expAddr));
    wbLine = memWdata;
    repeat (latency) begin
      @(negedge clk);
      checkOutput({tag, "_hold"}, 256'({memEn, p1Stall, memAddr}), 256'({2'b11, expAddr}));
    end
    memAck   = 1'b1;
    memRdata = line;
    @(negedge clk);
    memAck   = 1'b0;
  endtask

  initial begin
    #50000;
    $display("[TB] FAIL watchdog expired checks=%0d", checks);
    $fatal(1, "[TB] timeout");
  end

  initial begin
    for (int i = 0; i < 8; i++) begin
      line1[32*i +: 32] = 32'h1000_0000 + i;
      line2[32*i +: 32] = 32'h2000_0000 + i;
      line3[32*i +: 32] = 32'h3000_0000 + i;
      line4[32*i +: 32] = 32'h4000_0000 + i;
      line5[32*i +: 32] = 32'h5000_0000 + i;
      line6[32*i +: 32] = 32'h6000_0000 + i;
      junk[32*i +: 32]  = 32'hBAD0_0000 + i;
    end
    line1[32 +: 32] = 32'hDEAD_BEEF;

    rstN     = 1'b0;
    memAck   = 1'b0;
    memRdata = '0;
    applyStimulus(1'b0, 1'b0, 32'h0, 32'h0);
    #1;
    checkOutput("rst_en",    256'(memEn),   256'(1'b0));
    checkOutput("rst_we",    256'(memWe),   256'(1'b0));
    checkOutput("rst_addr",  256'(memAddr), 256'(32'h0));
    checkOutput("rst_wdata", memWdata,      256'(0));
    checkOutput("rst_rdata", 256'(p1Rdata), 256'(32'h0));
    checkOutput("rst_stall", 256'(p1Stall), 256'(1'b0));
    repeat (2) @(negedge clk);
    rstN = 1'b1;
    @(negedge clk);

    // Cold read miss to 0x404
    applyStimulus(1'b1, 1'b0, 32'h0000_0404, 32'h0);
    #1;
    checkOutput("cold_stall0", 256'(p1Stall), 256'(1'b1));
    memRespond("cold", 1'b0, 32'h0000_0400, 10, line1, wb);
    checkOutput("cold_refilled", 256'({p1Stall, memEn}), 256'(2'b10));
    @(negedge clk);
    checkOutput("cold_unstall", 256'(p1Stall), 256'(1'b0));
    checkOutput("cold_data",    256'(p1Rdata), 256'(32'hDEAD_BEEF));

    // Write hit then read back
    applyStimulus(1'b0, 1'b1, 32'h0000_0408, 32'h1234_5678);
    #1;
    checkOutput("wh_stall", 256'({p1Stall, memEn}), 256'(2'b00));
    @(negedge clk);
    checkOutput("wh_nomem", 256'({p1Stall, memEn}), 256'(2'b00));
    applyStimulus(1'b1, 1'b0, 32'h0000_0408, 32'h0);
    #1;
    checkOutput("wh_read",  256'(p1Rdata), 256'(32'h1234_5678));
    applyStimulus(1'b1, 1'b0, 32'h0000_0404, 32'h0);
    #1;
    checkOutput("wh_other", 256'(p1Rdata), 256'(32'hDEAD_BEEF));
    @(negedge clk);

    // Dirty eviction of line 0 by 0x808
    applyStimulus(1'b1, 1'b0, 32'h0000_0808, 32'h0);
    #1;
    checkOutput("ev_stall0", 256'(p1Stall), 256'(1'b1));
    memRespond("ev_wb", 1'b1, 32'h0000_0400, 3, junk, wb);
    checkOutput("ev_wb_w2", 256'(wb[64 +: 32]), 256'(32'h1234_5678));
    checkOutput("ev_wb_w1", 256'(wb[32 +: 32]), 256'(32'hDEAD_BEEF));
    memRespond("ev_rm", 1'b0, 32'h0000_0800, 4, line2, wb);
    checkOutput("ev_refilled", 256'(p1Stall), 256'(1'b1));
    @(negedge clk);
    checkOutput("ev_unstall", 256'(p1Stall), 256'(1'b0));
    checkOutput("ev_data",    256'(p1Rdata), 256'(32'h2000_0002));

    // Store miss to a clean line: refill only, then write-allocate
    applyStimulus(1'b0, 1'b1, 32'h0000_0C00, 32'hA5A5_A5A5);
    #1;
    checkOutput("sm_stall0", 256'(p1Stall), 256'(1'b1));
    memRespond("sm", 1'b0, 32'h0000_0C00, 2, line3, wb);
    checkOutput("sm_refilled", 256'(p1Stall), 256'(1'b1));
    @(negedge clk);
    checkOutput("sm_unstall", 256'(p1Stall), 256'(1'b0));
    @(negedge clk);
    applyStimulus(1'b1, 1'b0, 32'h0000_0C00, 32'h0);
    #1;
    checkOutput("sm_read", 256'(p1Rdata), 256'(32'hA5A5_A5A5));
    @(negedge clk);
    applyStimulus(1'b1, 1'b0, 32'h0000_1000, 32'h0);
    memRespond("sm_wb", 1'b1, 32'h0000_0C00, 1, junk, wb);
    checkOutput("sm_wb_w0", 256'(wb[0 +: 32]),  256'(32'hA5A5_A5A5));
    checkOutput("sm_wb_w1", 256'(wb[32 +: 32]), 256'(32'h3000_0001));
    memRespond("sm_rm", 1'b0, 32'h0000_1000, 1, line4, wb);
    @(negedge clk);
    checkOutput("sm_ev_data", 256'(p1Rdata), 256'(32'h4000_0000));

    // Spurious ack in IDLE
    applyStimulus(1'b0, 1'b0, 32'h0000_1000, 32'h0);
    memAck   = 1'b1;
    memRdata = junk;
    @(negedge clk);
    memAck = 1'b0;
    checkOutput("sp_idle", 256'({memEn, p1Stall}), 256'(2'b00));
    applyStimulus(1'b1, 1'b0, 32'h0000_1000, 32'h0);
    #1;
    checkOutput("sp_hit",  256'(p1Stall), 256'(1'b0));
    checkOutput("sp_data", 256'(p1Rdata), 256'(32'h4000_0000));
    @(negedge clk);

    // Ack coincident with the request cycle is ignored
    applyStimulus(1'b1, 1'b0, 32'h0000_0020, 32'h0);
    memAck   = 1'b1;
    memRdata = junk;
    @(negedge clk);
    memAck = 1'b0;
    checkOutput("ar_pending", 256'({memEn, p1Stall}), 256'(2'b11));
    memRespond("ar", 1'b0, 32'h0000_0020, 3, line5, wb);
    @(negedge clk);
    checkOutput("ar_data", 256'(p1Rdata), 256'(32'h5000_0000));

    // Reset in the middle of a refill
    applyStimulus(1'b1, 1'b0, 32'h0000_0040, 32'h0);
    @(negedge clk);
    checkOutput("rr_en", 256'(memEn), 256'(1'b1));
    @(negedge clk);
    rstN = 1'b0;
    #1;
    checkOutput("rr_en_drop", 256'(memEn),   256'(1'b0));
    checkOutput("rr_stall",   256'(p1Stall), 256'(1'b0));
    checkOutput("rr_addr",    256'(memAddr), 256'(32'h0));
    @(negedge clk);
    @(negedge clk);
    rstN = 1'b1;
    applyStimulus(1'b0, 1'b0, 32'h0000_0040, 32'h0);
    memAck   = 1'b1;
    memRdata = junk;
    @(negedge clk);
    memAck = 1'b0;
    checkOutput("rr_stray", 256'({memEn, p1Stall}), 256'(2'b00));
    applyStimulus(1'b1, 1'b0, 32'h0000_1000, 32'h0);
    #1;
    checkOutput("rr_inval", 256'(p1Stall), 256'(1'b1));
    applyStimulus(1'b1, 1'b0, 32'h0000_0040, 32'h0);
    #1;
    checkOutput("rr_remiss", 256'(p1Stall), 256'(1'b1));
    memRespond("rr", 1'b0, 32'h0000_0040, 2, line6, wb);
    @(negedge clk);
    checkOutput("rr_data", 256'(p1Rdata), 256'(32'h6000_0000));

    applyStimulus(1'b0, 1'b0, 32'h0, 32'h0);
    @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
